// File: rtl/fft_ctrl_pkg.sv
// rtl/fft_ctrl_pkg.sv - shared types and helpers for the FFT frame sequencer
//
// Purpose: state encoding, drop-counter ceiling and bit-reversal helper used
//          by fft_frame_seq.
// Ports:   none (package)
package fft_ctrl_pkg;

   typedef enum logic [2:0] {
      FILL     = 3'd0,
      START    = 3'd1,
      COMPUTE  = 3'd2,
      STREAM   = 3'd3,
      WAIT_DEC = 3'd4
   } state_t;

   localparam logic [15:0] DROP_MAX = 16'hFFFF;

   // Reverses the low n bits of v; bits at and above n come back as zero.
   // Shifting the result left one bit per step avoids any negative index.
   function automatic logic [31:0] bitrev(input logic [31:0] v, input int n);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < n) begin
            r = {r[30:0], v[i]};
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_frame_seq.sv
// rtl/fft_frame_seq.sv - frame sequencer: fill RAM, run FFT, stream bins, latch frequency
//
// Purpose: collects FFT_SIZE samples into the FFT working RAM, kicks the FFT
//          core, streams the finished bins in natural order to the frequency
//          decoder with an unbroken valid, and latches the decoded frequency.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   sample_valid, sample       audio sample strobe and value
//   ram_we/ram_waddr/ram_wdata RAM write port ({real, imag})
//   ram_raddr, ram_rdata       RAM read port, data one cycle after address
//   fft_start, fft_complete    FFT core handshake pulses
//   bin_data, bin_valid        bin stream to the decoder
//   note_dec, dec_freq         decoder decision pulse and frequency
//   frequency, freq_valid      latched frequency and update pulse
//   dropped_cnt                saturating count of samples dropped outside FILL
//   timeout_err                sticky compute/decode timeout flag
module fft_frame_seq
   import fft_ctrl_pkg::*;
#(
   parameter int BIT_WIDTH = 16,
   parameter int N         = 9,
   parameter int FFT_SIZE  = 512,
   parameter int BITREV    = 1,
   parameter int TIMEOUT   = 65535
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   sample_valid,
   input  logic [BIT_WIDTH-1:0]   sample,
   output logic                   ram_we,
   output logic [N-1:0]           ram_waddr,
   output logic [2*BIT_WIDTH-1:0] ram_wdata,
   output logic [N-1:0]           ram_raddr,
   input  logic [2*BIT_WIDTH-1:0] ram_rdata,
   output logic                   fft_start,
   input  logic                   fft_complete,
   output logic [2*BIT_WIDTH-1:0] bin_data,
   output logic                   bin_valid,
   input  logic                   note_dec,
   input  logic [11:0]            dec_freq,
   output logic [11:0]            frequency,
   output logic                   freq_valid,
   output logic [15:0]            dropped_cnt,
   output logic                   timeout_err
);

   localparam logic [N-1:0]  LAST_ADDR = N'(FFT_SIZE - 1);
   localparam logic [15:0]   TIMER_MAX = 16'(TIMEOUT);

   state_t         state;
   state_t         state_next;
   logic [N-1:0]   wcnt;
   logic [N-1:0]   rcnt;
   logic [15:0]    timer;
   logic           timeout_hit;
   logic           data_phase;   // ram_rdata currently carries a streamed bin
   logic [N-1:0]   rd_addr;

   // ------------------------------------------------------------------
   // Next-state and combinational outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_next  = state;
      ram_we      = 1'b0;
      fft_start   = 1'b0;
      timeout_hit = 1'b0;

      case (state)
         FILL: begin
            // Gated by reset so the write port is quiet while reset is held.
            ram_we = sample_valid & ~reset;
            if (sample_valid && wcnt == LAST_ADDR) begin
               state_next = START;
            end
         end
         START: begin
            fft_start  = 1'b1;
            state_next = COMPUTE;
         end
         COMPUTE: begin
            if (fft_complete) begin
               state_next = STREAM;
            end else if (timer == TIMER_MAX) begin
               timeout_hit = 1'b1;
               state_next  = FILL;
            end
         end
         STREAM: begin
            if (rcnt == LAST_ADDR) begin
               state_next = WAIT_DEC;
            end
         end
         WAIT_DEC: begin
            if (note_dec) begin
               state_next = FILL;
            end else if (timer == TIMER_MAX) begin
               timeout_hit = 1'b1;
               state_next  = FILL;
            end
         end
         default: begin
            state_next = FILL;
         end
      endcase
   end

   // Read address: natural bin order out of a bit-reversed result buffer.
   always_comb begin
      rd_addr = rcnt;
      if (BITREV != 0) begin
         rd_addr = N'(bitrev(32'(rcnt), N));
      end
   end

   assign ram_raddr = (state == STREAM) ? rd_addr : '0;
   assign ram_waddr = wcnt;
   assign ram_wdata = ram_we ? {sample, {BIT_WIDTH{1'b0}}} : '0;

   // Once the last bin has gone out, the decoder sees zero data with valid
   // still high until it decides.
   assign bin_data  = data_phase ? ram_rdata : '0;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= FILL;
      end else begin
         state <= state_next;
      end
   end

   // ------------------------------------------------------------------
   // Counters and registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wcnt        <= '0;
         rcnt        <= '0;
         timer       <= '0;
         data_phase  <= 1'b0;
         bin_valid   <= 1'b0;
         frequency   <= '0;
         freq_valid  <= 1'b0;
         dropped_cnt <= '0;
         timeout_err <= 1'b0;
      end else begin
         // Write counter wraps naturally at the end of a frame; a timeout
         // also forces the next frame to start at address 0.
         if (state == FILL && sample_valid) begin
            wcnt <= (wcnt == LAST_ADDR) ? '0 : wcnt + 1'b1;
         end else if (timeout_hit) begin
            wcnt <= '0;
         end

         if (state == STREAM) begin
            rcnt <= (rcnt == LAST_ADDR) ? '0 : rcnt + 1'b1;
         end else begin
            rcnt <= '0;
         end

         // Timer runs only in the two waiting states; START clears it for
         // COMPUTE and STREAM clears it for WAIT_DEC.
         if ((state == COMPUTE || state == WAIT_DEC) && timer != TIMER_MAX) begin
            timer <= timer + 1'b1;
         end else begin
            timer <= '0;
         end

         data_phase <= (state == STREAM);

         // Valid rises one cycle after the first address (RAM latency) and
         // stays up through WAIT_DEC until the decision or an abort.
         bin_valid <= (state == STREAM) ||
                      (state == WAIT_DEC && state_next == WAIT_DEC);

         freq_valid <= (state == WAIT_DEC) && note_dec;
         if (state == WAIT_DEC && note_dec) begin
            frequency <= dec_freq;
         end

         if (sample_valid && state != FILL && dropped_cnt != DROP_MAX) begin
            dropped_cnt <= dropped_cnt + 1'b1;
         end

         if (timeout_hit) begin
            timeout_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fft_frame_seq.sv
// tb/tb_fft_frame_seq.sv - directed self-checking bench for fft_frame_seq
module tb_fft_frame_seq;

   localparam int BW = 16;
   localparam int AW = 9;

   logic          clk = 1'b0;
   logic          reset;
   logic          sample_valid;
   logic [BW-1:0] sample;
   logic          ram_we;
   logic [AW-1:0] ram_waddr;
   logic [2*BW-1:0] ram_wdata;
   logic [AW-1:0] ram_raddr;
   logic [2*BW-1:0] ram_rdata;
   logic          fft_start;
   logic          fft_complete;
   logic [2*BW-1:0] bin_data;
   logic          bin_valid;
   logic          note_dec;
   logic [11:0]   dec_freq;
   logic [11:0]   frequency;
   logic          freq_valid;
   logic [15:0]   dropped_cnt;
   logic          timeout_err;

   int checks   = 0;
   int failures = 0;

   fft_frame_seq #(
      .BIT_WIDTH (BW),
      .N         (AW),
      .FFT_SIZE  (512),
      .BITREV    (1),
      .TIMEOUT   (100)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .sample_valid (sample_valid),
      .sample       (sample),
      .ram_we       (ram_we),
      .ram_waddr    (ram_waddr),
      .ram_wdata    (ram_wdata),
      .ram_raddr    (ram_raddr),
      .ram_rdata    (ram_rdata),
      .fft_start    (fft_start),
      .fft_complete (fft_complete),
      .bin_data     (bin_data),
      .bin_valid    (bin_valid),
      .note_dec     (note_dec),
      .dec_freq     (dec_freq),
      .frequency    (frequency),
      .freq_valid   (freq_valid),
      .dropped_cnt  (dropped_cnt),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;

   // RAM preloaded so that address a holds {a, 0}; one cycle read latency.
   always @(posedge clk) begin
      ram_rdata <= {{(BW-AW){1'b0}}, ram_raddr, {BW{1'b0}}};
   end

   function automatic logic [AW-1:0] brev(input int v);
      logic [AW-1:0] a;
      logic [AW-1:0] r;
      a = AW'(v);
      for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [15:0] first_bins [4];
   int n;

   initial begin
      first_bins[0] = 16'd0;
      first_bins[1] = 16'd256;
      first_bins[2] = 16'd128;
      first_bins[3] = 16'd384;

      reset = 1'b1; sample_valid = 1'b0; sample = '0;
      fft_complete = 1'b0; note_dec = 1'b0; dec_freq = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ram_we", ram_we, 0);
      chk("rst_fft_start", fft_start, 0);
      chk("rst_bin_valid", bin_valid, 0);
      chk("rst_bin_data", bin_data, 0);
      chk("rst_freq_valid", freq_valid, 0);
      chk("rst_frequency", frequency, 0);
      chk("rst_dropped", dropped_cnt, 0);
      chk("rst_timeout", timeout_err, 0);
      reset = 1'b0;

      // ---- Test 1: 512 samples at 1 per 4 cycles ----
      for (int i = 0; i < 512; i++) begin
         sample_valid = 1'b1;
         sample = BW'(i);
         #1;
         chk("fill_we", ram_we, 1);
         chk("fill_waddr", ram_waddr, i);
         chk("fill_wdata", ram_wdata, {16'(i), 16'h0});
         tick();
         sample_valid = 1'b0;
         if (i != 511) begin
            chk("fill_no_start", fft_start, 0);
            repeat (3) tick();
         end
      end
      // START cycle, with a sample arriving in it (dropped)
      sample_valid = 1'b1;
      sample = 16'h7777;
      #1;
      chk("start_pulse", fft_start, 1);
      chk("start_no_we", ram_we, 0);
      tick();
      chk("start_one_cycle", fft_start, 0);
      repeat (4) tick();
      sample_valid = 1'b0;
      repeat (3) tick();
      chk("drops_compute", dropped_cnt, 5);

      // ---- Test 2: bit-reversed stream ----
      fft_complete = 1'b1;
      tick();
      fft_complete = 1'b0;
      chk("stream_raddr0", ram_raddr, 0);
      chk("stream_valid_lat", bin_valid, 0);
      for (int k = 0; k < 512; k++) begin
         tick();
         chk("stream_valid", bin_valid, 1);
         chk("stream_data", bin_data, {7'b0, brev(k), 16'h0});
         if (k < 4) chk("stream_first", bin_data[31:16], first_bins[k]);
         if (k < 511) chk("stream_raddr", ram_raddr, brev(k + 1));
         sample_valid = (k >= 10 && k < 15);
      end
      sample_valid = 1'b0;

      // ---- Test 3: decoder answers 3 cycles after the stream ----
      for (int j = 0; j < 3; j++) begin
         tick();
         chk("wait_valid", bin_valid, 1);
         chk("wait_data", bin_data, 0);
         chk("wait_no_fv", freq_valid, 0);
      end
      note_dec = 1'b1;
      dec_freq = 12'd440;
      #1;
      chk("dec_valid_held", bin_valid, 1);
      tick();
      note_dec = 1'b0;
      dec_freq = 12'd0;
      chk("dec_frequency", frequency, 440);
      chk("dec_freq_valid", freq_valid, 1);
      chk("dec_bin_valid_fall", bin_valid, 0);
      tick();
      chk("dec_fv_one_cycle", freq_valid, 0);
      chk("dec_freq_hold", frequency, 440);

      // ---- Test 4: drop count, next frame from address 0 ----
      chk("drops_total", dropped_cnt, 10);
      for (int i = 0; i < 512; i++) begin
         sample_valid = 1'b1;
         sample = BW'(i + 1000);
         #1;
         if (i == 0) chk("frame2_waddr0", ram_waddr, 0);
         if (i == 511) chk("frame2_waddr_last", ram_waddr, 511);
         chk("frame2_we", ram_we, 1);
         tick();
      end
      sample_valid = 1'b0;
      #1;
      chk("frame2_start", fft_start, 1);

      // ---- Test 5: fft_complete withheld -> timeout ----
      repeat (50) tick();
      chk("timeout_not_yet", timeout_err, 0);
      n = 0;
      while (!timeout_err && n < 200) begin
         tick();
         n++;
      end
      chk("timeout_set", timeout_err, 1);
      chk("timeout_window", (n >= 51 && n <= 53), 1);
      chk("timeout_freq_kept", frequency, 440);
      chk("timeout_no_fv", freq_valid, 0);
      chk("timeout_bin_valid", bin_valid, 0);
      chk("timeout_drops_kept", dropped_cnt, 10);
      fft_complete = 1'b1;
      tick();
      fft_complete = 1'b0;
      chk("stray_no_raddr", ram_raddr, 0);
      chk("stray_no_valid", bin_valid, 0);
      tick();
      chk("stray_no_valid2", bin_valid, 0);
      chk("stray_no_start", fft_start, 0);
      sample_valid = 1'b1;
      sample = 16'd7;
      #1;
      chk("after_to_we", ram_we, 1);
      chk("after_to_waddr", ram_waddr, 0);
      tick();

      // ---- Test 6: reset in the middle of STREAM ----
      for (int i = 1; i < 512; i++) begin
         sample = BW'(i);
         tick();
      end
      sample_valid = 1'b0;
      #1;
      chk("frame3_start", fft_start, 1);
      repeat (3) tick();
      fft_complete = 1'b1;
      tick();
      fft_complete = 1'b0;
      repeat (20) tick();
      chk("frame3_streaming", bin_valid, 1);
      #3;
      reset = 1'b1;
      #1;
      chk("mid_rst_bin_valid", bin_valid, 0);
      chk("mid_rst_bin_data", bin_data, 0);
      chk("mid_rst_raddr", ram_raddr, 0);
      chk("mid_rst_start", fft_start, 0);
      chk("mid_rst_frequency", frequency, 0);
      chk("mid_rst_timeout", timeout_err, 0);
      chk("mid_rst_dropped", dropped_cnt, 0);
      chk("mid_rst_we", ram_we, 0);
      tick();
      reset = 1'b0;
      sample_valid = 1'b1;
      sample = 16'd5;
      #1;
      chk("post_rst_we", ram_we, 1);
      chk("post_rst_waddr", ram_waddr, 0);
      chk("post_rst_wdata", ram_wdata, {16'd5, 16'h0});
      tick();
      sample_valid = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
